driver_motor_paso: RTL
======================

// Module: driver_motor_paso
// PURPOSE
// Per-axis stepper driver on the receiving end of the motion controller's direction commands.
// Turns s_out_*_pos/neg pulses into coil phase sequences at a fixed step rate and keeps the axis
// position counter that feeds theta_actual/phi_actual. One instance per axis (theta, phi).
// PARAMETERS
// PRESC          50000  clk cycles per step tick (>=2)
// STEPS_PER_REV  360    position units per revolution; position wraps modulo this
// HOLD_TICKS     100    ticks coils stay energized after command drops before release
// PORTS
// clk           in   1   system clock
// rst           in   1   synchronous reset, active-high
// s_in_pos      in   2   clockwise command; active iff ==2'b01
// s_in_neg      in   2   counter-clockwise command; active iff ==2'b01
// pos_load      in   1   load pos_load_val into position (homing)
// pos_load_val  in   16  preset value, must be < STEPS_PER_REV
// bobinas       out  4   coil drive A,B,C,D
// pos_actual    out  16  current position, 0..STEPS_PER_REV-1
// moving        out  1   high while in RUN
// err_cmd       out  1   high in any cycle where both commands are active
// BEHAVIOUR
// - Reset: bobinas=0, pos_actual=0, moving=0, err_cmd=0, state=OFF, tick count=0, phase idx=1.
// - cmd = exactly one of s_in_pos/s_in_neg active. Both active -> err_cmd=1 that cycle, treated as no cmd.
// - Phase table idx0..7: 1000,1100,0100,0110,0010,0011,0001,1001. bobinas=table[idx] except in OFF (0000).
// - Tick: counter counts 0..PRESC-1 in RUN/HOLD; tick on PRESC-1, then back to 0.
// - FSM: OFF --cmd--> RUN (coils energized same edge, counter=0).
//   RUN: on tick, step. cmd drop -> HOLD (counter and hold count =0).
//   HOLD: cmd -> RUN (counter=0). HOLD_TICKS ticks, no cmd -> OFF.
// - Step: s_in_pos decrements idx and pos_actual; s_in_neg increments both.
//   Idx wraps mod 8. pos wraps 0 <-> STEPS_PER_REV-1.
//   So pos command drives actual toward a lower target, as the controller expects.
// - First step: PRESC cycles after cmd first sampled. Direction reversal in RUN applies at next tick.
//   Counter is not reset.
// - Direction is sampled on the tick cycle. Cmd gone on that cycle -> no step (exit to HOLD).
// - pos_load wins over a same-cycle step for pos_actual. Phase idx still advances. Load allowed in any state.
// - Outputs registered. pos_actual updates the edge after the tick.
// - rst mid-run: all state to reset values on that edge; coils released immediately.
// CONFIGURATION
// - DRIVER_MOTOR_HALF_STEP_EN defined: idx moves +-1 per step (8-state half step).
// - Undefined: idx moves +-2 per step, staying on odd entries 1100,0110,0011,1001 (two-phase full step).
//   Reset idx=1 keeps this valid.
// - Position units per step are 1 in both modes. Set STEPS_PER_REV to match the mode.
// STRUCTURE
// - Package control_motor_pkg: state encodings (OFF/RUN/HOLD), CMD_ACTIVE=2'b01, 8-entry phase table.
//   Shared with control_movimiento users.
// - Sub-module tick_pasos: PRESC prescaler with sync clear and tick output.
//   Counter width = clog2(PRESC).
// - FSM, phase index, position counter and hold counter live in this module.
// TESTING (PRESC=4, HOLD_TICKS=3, STEPS_PER_REV=360)
// 1. rst 2 cycles -> bobinas=0000, pos_actual=0, moving=0.
//    Then s_in_neg=01 held -> bobinas=1100 next edge.
//    Full-step: 0110 and pos=1 after 4 cycles, 0011 and pos=2 after 8.
// 2. From pos=0, s_in_pos=01 for 1 tick -> pos_actual=359 (wrap).
//    Load 359, s_in_neg 1 tick -> pos_actual=0.
// 3. s_in_pos=01 and s_in_neg=01 together -> err_cmd=1, no step.
//    State OFF stays OFF; state RUN exits to HOLD.
// 4. Cmd dropped in RUN -> moving=0, coils held 12 cycles, then 0000.
//    Cmd reasserted at cycle 6 of HOLD -> RUN, coils unchanged, next step 4 cycles later.
// 5. pos_load=1, val=90 on a tick cycle with s_in_neg -> pos_actual=90, phase still advances.
//    rst asserted mid-RUN -> reset values next edge.
// 6. HALF_STEP_EN build: s_in_neg from reset -> 1100,0100,0110 per tick.
//    s_in_pos reverses -> 0100.

Source files
------------

// File: rtl/control_motor_pkg.sv
// control_motor_pkg: shared stepper states, command encoding and coil phase table
package control_motor_pkg;
  typedef enum logic [1:0] {OFF, RUN, HOLD} state_t;
  localparam logic [1:0] CMD_ACTIVE = 2'b01;
  localparam logic [3:0] PHASES [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                        4'b0010, 4'b0011, 4'b0001, 4'b1001};
endpackage

// File: rtl/driver_motor_paso_if.sv
// driver_motor_paso_if: command/position bus between motion controller and stepper driver
interface driver_motor_paso_if;
  logic [1:0]  s_in_pos;
  logic [1:0]  s_in_neg;
  logic        pos_load;
  logic [15:0] pos_load_val;
  logic [3:0]  bobinas;
  logic [15:0] pos_actual;
  logic        moving;
  logic        err_cmd;
  modport master (output s_in_pos, s_in_neg, pos_load, pos_load_val,
                  input bobinas, pos_actual, moving, err_cmd);
  modport slave (input s_in_pos, s_in_neg, pos_load, pos_load_val,
                 output bobinas, pos_actual, moving, err_cmd);
endinterface

// File: rtl/tick_pasos.sv
// tick_pasos: step-rate prescaler, one tick every PRESC enabled cycles, sync clear
module tick_pasos #(
  parameter int PRESC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(PRESC);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(PRESC - 1);
  // count 0..PRESC-1 while enabled, restarting on clear or after each tick
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/driver_motor_paso.sv
// driver_motor_paso: per-axis stepper driver; DRIVER_MOTOR_HALF_STEP_EN selects half step (default full step)
module driver_motor_paso
  import control_motor_pkg::*;
#(
  parameter int PRESC         = 50000,
  parameter int STEPS_PER_REV = 360,
  parameter int HOLD_TICKS    = 100
) (
  input logic clk,
  input logic rst,
  driver_motor_paso_if.slave bus
);
`ifdef DRIVER_MOTOR_HALF_STEP_EN
  localparam logic [2:0] IDX_STEP = 3'd1;
`else
  localparam logic [2:0] IDX_STEP = 3'd2;
`endif
  localparam int HW = $clog2(HOLD_TICKS + 1);
  state_t state;
  logic [2:0] idx, idx_nx;
  logic [HW-1:0] hold_cnt;
  logic pos_on, neg_on, cmd, step, tick, clr;
  assign pos_on = bus.s_in_pos == CMD_ACTIVE;
  assign neg_on = bus.s_in_neg == CMD_ACTIVE;
  assign cmd    = pos_on ^ neg_on;
  assign step   = state == RUN && cmd && tick;
  assign idx_nx = step ? (neg_on ? idx + IDX_STEP : idx - IDX_STEP) : idx;
  assign clr    = state == OFF || (state == RUN && !cmd) || (state == HOLD && cmd);
  tick_pasos #(.PRESC(PRESC)) u_tick (
    .clk(clk), .rst(rst), .en(state != OFF), .clr(clr), .tick(tick)
  );
  // run/hold/release FSM with phase index, position and registered coil outputs
  always_ff @(posedge clk)
    if (rst) begin
      state          <= OFF;
      idx            <= 3'd1;
      hold_cnt       <= '0;
      bus.bobinas    <= '0;
      bus.pos_actual <= '0;
      bus.moving     <= 1'b0;
      bus.err_cmd    <= 1'b0;
    end else begin
      bus.err_cmd <= pos_on && neg_on;
      idx         <= idx_nx;
      if (bus.pos_load) bus.pos_actual <= bus.pos_load_val;
      else if (step && neg_on)
        bus.pos_actual <= bus.pos_actual == 16'(STEPS_PER_REV - 1) ? '0 : bus.pos_actual + 1'b1;
      else if (step)
        bus.pos_actual <= bus.pos_actual == '0 ? 16'(STEPS_PER_REV - 1) : bus.pos_actual - 1'b1;
      case (state)
        OFF:
          if (cmd) begin
            state       <= RUN;
            bus.moving  <= 1'b1;
            bus.bobinas <= PHASES[idx];
          end
        RUN: begin
          bus.bobinas <= PHASES[idx_nx];
          if (!cmd) begin
            state      <= HOLD;
            bus.moving <= 1'b0;
            hold_cnt   <= '0;
          end
        end
        HOLD:
          if (cmd) begin
            state      <= RUN;
            bus.moving <= 1'b1;
          end else if (tick) begin
            if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
              state       <= OFF;
              bus.bobinas <= '0;
            end else hold_cnt <= hold_cnt + 1'b1;
          end
        default: state <= OFF;
      endcase
    end
endmodule
